// File: rtl/regfile_dump.sv
// ==== regfile_dump : streams a regfile address range over valid/ready (rev 1.0)
// ==== optional trailing XOR checksum word enabled by REGFILE_DUMP_CHECKSUM_EN
`default_nettype none

module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_READ = 3'd1, S_SEND = 3'd2, S_CSUM = 3'd3, S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_READ = 3'd1, S_SEND = 3'd2, S_DONE = 3'd4
    } state_t;
`endif

    localparam logic [4:0] C_FIRST = 5'(FIRST_REG);
    localparam logic [4:0] C_LAST  = 5'(LAST_REG);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_idx_q, out_idx_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    idx_d   = C_FIRST;
                    busy_d  = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d  = 32'd0;
`endif
                end
            end
            S_READ: begin
                state_d     = S_SEND;
                out_valid_d = 1'b1;
                out_data_d  = rd_data;
                out_idx_d   = idx_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                csum_d      = csum_q ^ rd_data;
`else
                out_last_d  = (idx_q == C_LAST);
`endif
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (idx_q == C_LAST) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        // Accumulator already holds every dumped word at this point
                        state_d     = S_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = csum_q;
                        out_idx_d   = 5'd0;
                        out_last_d  = 1'b1;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_READ;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over a same-cycle handshake: the word is dropped unaccepted
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_d      = 32'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_idx_q   <= 5'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rd_addr   = (state_q == S_READ || state_q == S_SEND) ? idx_q : 5'd0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// ==== tb_regfile_dump : randomized bench for regfile_dump against a word-list reference model (rev 1.0)
`default_nettype none

module tb_regfile_dump;

    localparam int FIRST = 0;
    localparam int LAST  = 31;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, abort, out_ready;
    logic [4:0]  rd_addr, out_idx;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start5, abort5, ready5;
    logic [4:0]  rd_addr5, out_idx5;
    logic [31:0] rd_data5, out_data5;
    logic        out_valid5, out_last5, busy5, done5;

    logic [31:0] rf [32];
    assign rd_data  = rf[rd_addr];
    assign rd_data5 = rf[rd_addr5];

    regfile_dump dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort5),
        .rd_addr(rd_addr5), .rd_data(rd_data5),
        .out_valid(out_valid5), .out_ready(ready5), .out_data(out_data5),
        .out_idx(out_idx5), .out_last(out_last5), .busy(busy5), .done(done5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: collects accepted words and verifies hold-while-stalled
    logic [37:0] got_q [$];
    logic [37:0] word_p;
    bit          stall_p = 0, abort_p = 0, done_seen = 0;
    int          done_cyc = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_p && !abort_p) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_word", {out_data, out_idx, out_last}, word_p);
            end
            if (out_valid && out_ready && !abort)
                got_q.push_back({out_data, out_idx, out_last});
            stall_p = out_valid && !out_ready;
            abort_p = abort;
            word_p  = {out_data, out_idx, out_last};
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                done_cnt++;
            end
        end else begin
            stall_p = 0;
        end
    end

    // Reference: the dump is the register values FIRST..LAST in order, plus optional XOR word
    task automatic compare_words();
        logic [37:0] exp_q [$];
        logic [31:0] x = 32'd0;
        for (int i = FIRST; i <= LAST; i++) begin
            exp_q.push_back({rf[i], 5'(i), (i == LAST && CSUM == 0) ? 1'b1 : 1'b0});
            x = x ^ rf[i];
        end
        if (CSUM != 0) exp_q.push_back({x, 5'd0, 1'b1});
        check("n_words", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);
    endtask

    task automatic dump_and_check(input bit rnd, input bit hold_start);
        int start_cyc, n0;
        got_q.delete();
        done_seen = 0;
        n0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = hold_start;
        check("start_busy", busy, 1'b1);
        check("start_valid", out_valid, 1'b0);
        check("start_rdaddr", rd_addr, 5'(FIRST));
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        for (int k = 0; k < 800 && !done_seen; k++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", done_seen, 1'b1);
        if (!rnd) check("done_latency", done_cyc - start_cyc, 2 * (LAST - FIRST + 1) + CSUM);
        check("done_count", done_cnt - n0, 1);
        @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        compare_words();
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start5 = 1'b0; abort5 = 1'b0; ready5 = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;

        repeat (3) @(posedge clk); #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'd0);
        check("rst_idx", out_idx, 5'd0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdaddr", rd_addr, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dump_and_check(1'b0, 1'b0);

        // Single-register range
        rf[5] = 32'hDEAD_BEEF;
        @(posedge clk); #1; start5 = 1'b1;
        @(posedge clk); #1; start5 = 1'b0;
        check("s5_busy", busy5, 1'b1);
        check("s5_rdaddr", rd_addr5, 5'd5);
        @(posedge clk); #1;
        check("s5_valid", out_valid5, 1'b1);
        check("s5_data", out_data5, 32'hDEAD_BEEF);
        check("s5_idx", out_idx5, 5'd5);
        check("s5_last", out_last5, (CSUM == 0) ? 1'b1 : 1'b0);
        if (CSUM != 0) begin
            @(posedge clk); #1;
            check("s5_csum", {out_data5, out_idx5, out_last5}, {32'hDEAD_BEEF, 5'd0, 1'b1});
        end
        @(posedge clk); #1;
        check("s5_done", done5, 1'b1);
        check("s5_valid_off", out_valid5, 1'b0);
        @(posedge clk); #1;
        check("s5_idle", {busy5, done5}, 2'b00);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        dump_and_check(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        dump_and_check(1'b1, 1'b1);
        dump_and_check(1'b0, 1'b1);

        // Abort during SEND of idx 7 with out_ready high
        got_q.delete();
        n0 = done_cnt;
        @(posedge clk); #1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 100 && !(out_valid && out_idx == 5'd7); k++) begin
            @(posedge clk); #1;
        end
        check("abort_reach7", {out_valid, out_idx}, {1'b1, 5'd7});
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (5) @(posedge clk); #1;
        check("abort_nodone", done_cnt - n0, 0);
        check("abort_words", got_q.size(), 7);
        check("abort_rdaddr", rd_addr, 5'd0);
        dump_and_check(1'b0, 1'b0);

        // Asynchronous reset in the middle of a dump
        n0 = done_cnt;
        @(posedge clk); #1; start = 1'b1; out_ready = 1'b1;
        repeat (9) @(posedge clk); #3;
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_outs", {out_valid, out_data, out_idx, out_last, busy, done, rd_addr}, 46'd0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("arst_idle", busy, 1'b0);
        check("arst_nodone", done_cnt - n0, 0);

`ifdef REGFILE_DUMP_CHECKSUM_EN
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'h0F0F_0F0F;
        rf[2] = 32'hFF00_FF00;
        dump_and_check(1'b0, 1'b0);
        check("csum_word", (got_q.size() == 33) ? got_q[32] : 38'd0, {32'hF00F_F00F, 5'd0, 1'b1});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
